score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Two-digit BCD score counter feeding the VGA pixel generator's score0 (ones) / score1 (tens).
//  Counts rising edges of a game-logic point signal, detects the win score, and
//  publishes displayed digits only at frame start (vsync assertion), so a digit never
//  changes mid-frame (no tearing).
// PARAMETERS
//  WIN_TENS        1  tens digit of winning score (BCD 0..9)
//  WIN_ONES        0  ones digit of winning score (BCD 0..9); {WIN_TENS,WIN_ONES} must be 01..99
//  VSYNC_ACT_LOW   1  1: vsync pulse is active-low (640x480); 0: active-high
// PORTS
//  clk        in   1  system clock (same domain as VGA counters)
//  rst        in   1  synchronous, active-high reset
//  point      in   1  level from game logic; each 0->1 transition scores one point
//  clear      in   1  1-cycle synchronous restart of the game (score to 00, state PLAY)
//  vsync      in   1  VGA vsync from the VGA timing controller
//  score0     out  4  displayed ones digit (BCD), registered
//  score1     out  4  displayed tens digit (BCD), registered
//  game_over  out  1  1 while state == OVER, registered
// BEHAVIOUR
//  Reset: score0=0, score1=0, game_over=0, live ones/tens=0, state=PLAY,
//   point_d=1 (a point held high through reset is not counted), vsync_d=inactive level.
//  Edge detect: pt_pulse = point & ~point_d; point_d <= point every cycle.
//  Frame start: fs = vsync_d inactive & vsync active (one cycle per frame); vsync_d <= vsync.
//  Live counter (ones_l, tens_l), priority clear > pt_pulse:
//   - clear: ones_l=0, tens_l=0, state<=PLAY, same-cycle pt_pulse dropped.
//   - PLAY & pt_pulse: ones_l==9 -> ones_l=0, tens_l+1; else ones_l+1.
//     At 99 the counter holds (unreachable with legal WIN, kept as guard).
//   - OVER: pt_pulse ignored; counter holds.
//  FSM (2 states):
//   PLAY -> OVER when pt_pulse increments live value to {WIN_TENS,WIN_ONES};
//     live value and state update on the same edge.
//   OVER -> PLAY only on clear (or rst).
//  game_over = (state == OVER); changes on the FSM edge, not frame-aligned.
//  Display: on fs, score0<=ones_l, score1<=tens_l (values as of that cycle, pre-update);
//   otherwise hold. fs and pt_pulse same cycle -> display gets old value, new value at
//   next fs. clear does not touch score0/score1 until next fs; rst clears them at once.
//  Latency: point edge at cycle N -> live value at N+1 -> visible at first fs after N.
//  Outputs always BCD 0..9; no X on any output after reset.
// STRUCTURE
//  Package score_pkg: state encoding (ST_PLAY=1'b0, ST_OVER=1'b1), BCD_MAX=4'd9.
//  One natural sub-module: bcd_digit (4-bit BCD, inc/clr inputs, carry-out at 9);
//   instantiated twice, tens incremented by ones carry.
//  Edge detectors and frame-sync register stay inline in score_keeper.
// TESTING
//  1 rst, then 3 point pulses (2 cycles high each), one fs -> score1=0, score0=3.
//  2 9 pulses, then 1 more pulse, then fs -> digits 1,0; game_over=1 one cycle after
//    10th edge, before fs (WIN=10).
//  3 In OVER, 5 more pulses + fs -> digits stay 1,0; clear -> game_over=0 next cycle,
//    display stays 1,0 until next fs, then 0,0.
//  4 pt_pulse and fs in same cycle with live=04 -> display 04; next fs -> 05.
//  5 point held high across rst release -> no count; clear and pt_pulse same cycle ->
//    live 00, not 01.
//  6 rst asserted mid-game (live=07, display=06) -> next cycle all outputs 0, state PLAY;
//    repeat with VSYNC_ACT_LOW=0 and inverted vsync -> identical digit sequence.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the two-digit BCD score keeper.
package score_pkg;

  // Game state: counting points, or holding the winning score.
  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  // Largest value one BCD digit may hold.
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage : score_pkg

// File: rtl/score_keeper_bcd_digit.sv
// One BCD digit: synchronous clear, increment with wrap 9 -> 0.
// carry is the terminal-count flag (digit at 9); the caller qualifies it
// with its own increment to ripple into the next digit.
module bcd_digit
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] value,
  output logic       carry
);

  logic [3:0] value_r;

  // Digit register: reset/clear to zero, otherwise count in BCD on inc.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= 4'd0;
    end else if (clr) begin
      value_r <= 4'd0;
    end else if (inc) begin
      if (value_r >= BCD_MAX) begin
        value_r <= 4'd0;
      end else begin
        value_r <= value_r + 4'd1;
      end
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;
  assign carry = (value_r == BCD_MAX);

endmodule : bcd_digit

// File: rtl/score_keeper.sv
// Two-digit BCD score counter. Counts rising edges of point, stops at the
// winning score, and copies the live score to the display outputs only at
// frame start so a digit never changes mid-frame.
module score_keeper
  import score_pkg::*;
#(
  parameter logic [3:0] WIN_TENS      = 4'd1,
  parameter logic [3:0] WIN_ONES      = 4'd0,
  parameter logic       VSYNC_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       point,
  input  logic       clear,
  input  logic       vsync,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       game_over
);

  logic       point_d_r;
  logic       vsync_d_r;
  state_t     state_r;
  state_t     state_nxt_s;
  logic       pt_pulse_s;
  logic       vsync_act_s;
  logic       vsync_d_act_s;
  logic       fs_s;
  logic       count_en_s;
  logic       tens_inc_s;
  logic       win_hit_s;
  logic [3:0] ones_s;
  logic [3:0] tens_s;
  logic       ones_carry_s;
  logic       tens_carry_s;
  logic [3:0] ones_nxt_s;
  logic [3:0] tens_nxt_s;

  // Normalise vsync polarity so "1" always means the pulse is active.
  assign vsync_act_s   = vsync ^ VSYNC_ACT_LOW;
  assign vsync_d_act_s = vsync_d_r ^ VSYNC_ACT_LOW;
  assign fs_s          = vsync_act_s & ~vsync_d_act_s;
  assign pt_pulse_s    = point & ~point_d_r;

  // Edge-detect history; point_d resets high so a point held through reset is not scored.
  always_ff @(posedge clk) begin
    if (rst) begin
      point_d_r <= 1'b1;
      vsync_d_r <= VSYNC_ACT_LOW;
    end else begin
      point_d_r <= point;
      vsync_d_r <= vsync;
    end
  end

  // Count qualification and the value the counter is about to take.
  always_comb begin
    count_en_s = 1'b0;
    tens_inc_s = 1'b0;
    ones_nxt_s = ones_s;
    tens_nxt_s = tens_s;
    win_hit_s  = 1'b0;
    if (clear) begin
      count_en_s = 1'b0;
    end else if ((state_r == ST_PLAY) && pt_pulse_s && !(ones_carry_s && tens_carry_s)) begin
      count_en_s = 1'b1;
    end else begin
      count_en_s = 1'b0;
    end
    tens_inc_s = count_en_s & ones_carry_s;
    if (ones_carry_s) begin
      ones_nxt_s = 4'd0;
      tens_nxt_s = tens_s + 4'd1;
    end else begin
      ones_nxt_s = ones_s + 4'd1;
      tens_nxt_s = tens_s;
    end
    win_hit_s = count_en_s && (ones_nxt_s == WIN_ONES) && (tens_nxt_s == WIN_TENS);
  end

  bcd_digit u_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (count_en_s),
    .value (ones_s),
    .carry (ones_carry_s)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (tens_inc_s),
    .value (tens_s),
    .carry (tens_carry_s)
  );

  // Game state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_PLAY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: clear always restarts, winning point ends the game.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_PLAY: begin
        if (clear) begin
          state_nxt_s = ST_PLAY;
        end else if (win_hit_s) begin
          state_nxt_s = ST_OVER;
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (clear) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_OVER;
        end
      end
      default: state_nxt_s = ST_PLAY;
    endcase
  end

  // Registered outputs: digits follow the live score only at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      score0    <= 4'd0;
      score1    <= 4'd0;
      game_over <= 1'b0;
    end else begin
      game_over <= (state_nxt_s == ST_OVER);
      if (fs_s) begin
        score0 <= ones_s;
        score1 <= tens_s;
      end else begin
        score0 <= score0;
        score1 <= score1;
      end
    end
  end

endmodule : score_keeper

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper. Two instances share stimulus: one with
// active-low vsync, one with active-high fed the inverted vsync; both must
// show the same digits. Expected display values are queued as each step is
// driven and popped at the sample point.
module tb_score_keeper;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s0;
    logic       go;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       point;
  logic       clear;
  logic       vsync;
  logic       vsync_b;
  logic [3:0] a_s0, a_s1, b_s0, b_s1;
  logic       a_go, b_go;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  assign vsync_b = ~vsync;

  always #5 clk = ~clk;

  score_keeper #(.WIN_TENS(4'd1), .WIN_ONES(4'd0), .VSYNC_ACT_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .point(point), .clear(clear), .vsync(vsync),
    .score0(a_s0), .score1(a_s1), .game_over(a_go)
  );

  score_keeper #(.WIN_TENS(4'd1), .WIN_ONES(4'd0), .VSYNC_ACT_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .point(point), .clear(clear), .vsync(vsync_b),
    .score0(b_s0), .score1(b_s1), .game_over(b_go)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full point: two cycles high, one low.
  task automatic pulse();
    point = 1'b1;
    tick();
    tick();
    point = 1'b0;
    tick();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  // One vsync pulse (one cycle active) -> exactly one frame start.
  task automatic frame();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
  endtask

  task automatic expect_out(input logic [3:0] s1, input logic [3:0] s0, input logic go);
    exp_t e;
    e.s1 = s1;
    e.s0 = s0;
    e.go = go;
    q.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
    end else begin
      e = q.pop_front();
      cmp({tag, ".a.score1"}, a_s1, e.s1);
      cmp({tag, ".a.score0"}, a_s0, e.s0);
      cmp({tag, ".a.game_over"}, {3'd0, a_go}, {3'd0, e.go});
      cmp({tag, ".b.score1"}, b_s1, e.s1);
      cmp({tag, ".b.score0"}, b_s0, e.s0);
      cmp({tag, ".b.game_over"}, {3'd0, b_go}, {3'd0, e.go});
    end
  endtask

  initial begin
    rst   = 1'b1;
    point = 1'b0;
    clear = 1'b0;
    vsync = 1'b1;
    tick();
    tick();
    expect_out(4'd0, 4'd0, 1'b0);
    check("reset");
    rst = 1'b0;
    tick();

    // Three points: display must not move until a frame start.
    pulses(3);
    expect_out(4'd0, 4'd0, 1'b0);
    check("pre_fs_hold");
    frame();
    expect_out(4'd0, 4'd3, 1'b0);
    check("three_points");

    // Up to 9, then the winning 10th point.
    pulses(6);
    expect_out(4'd0, 4'd3, 1'b0);
    check("live9_not_over");
    point = 1'b1;
    tick();
    expect_out(4'd0, 4'd3, 1'b1);
    check("win_before_fs");
    tick();
    point = 1'b0;
    tick();
    frame();
    expect_out(4'd1, 4'd0, 1'b1);
    check("win_display");

    // Points ignored while OVER; clear restarts but display waits for fs.
    pulses(5);
    frame();
    expect_out(4'd1, 4'd0, 1'b1);
    check("over_ignores");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expect_out(4'd1, 4'd0, 1'b0);
    check("clear_no_fs");
    frame();
    expect_out(4'd0, 4'd0, 1'b0);
    check("clear_after_fs");

    // Point edge coincident with frame start: display shows old value.
    pulses(4);
    point = 1'b1;
    vsync = 1'b0;
    tick();
    expect_out(4'd0, 4'd4, 1'b0);
    check("pt_fs_same");
    vsync = 1'b1;
    tick();
    point = 1'b0;
    tick();
    frame();
    expect_out(4'd0, 4'd5, 1'b0);
    check("pt_fs_next");

    // Point held high across reset release is not counted.
    point = 1'b1;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    point = 1'b0;
    tick();
    frame();
    expect_out(4'd0, 4'd0, 1'b0);
    check("held_through_rst");

    // clear wins over a same-cycle point edge.
    pulses(2);
    point = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    point = 1'b0;
    tick();
    frame();
    expect_out(4'd0, 4'd0, 1'b0);
    check("clear_beats_pt");
    pulse();
    frame();
    expect_out(4'd0, 4'd1, 1'b0);
    check("count_after_clear");

    // Mid-game reset with live 07, display 06.
    pulses(5);
    frame();
    expect_out(4'd0, 4'd6, 1'b0);
    check("disp06");
    pulse();
    rst = 1'b1;
    tick();
    expect_out(4'd0, 4'd0, 1'b0);
    check("mid_rst");
    rst = 1'b0;
    tick();
    pulse();
    frame();
    expect_out(4'd0, 4'd1, 1'b0);
    check("after_mid_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_score_keeper
